mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Sequencer for the RV32M multiply/divide path attached to the execute stage. Accepts one M-extension operation from EX and runs it iteratively over 32 cycles, or through a single-cycle fast path for RISC-V special cases. Holds the pipeline with a stall request until the result is ready, then presents the result for EX to write back. Aborts cleanly when the instruction is flushed.

## Interface
- No parameters; operand width fixed at 32.
- `clk  in  1  core clock, rising edge`
- `rst  in  1  asynchronous reset, active-low`
- `start_i  in  1  EX holds an M-op; op/operands stable while stallreq_o=1`
- `op_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU`
- `reg1_i  in  32  rs1 value (multiplicand / dividend)`
- `reg2_i  in  32  rs2 value (multiplier / divisor)`
- `annul_i  in  1  flush; abort current op`
- `result_o  out  32  result, valid while ready_o=1`
- `ready_o  out  1  one-cycle result-valid pulse`
- `stallreq_o  out  1  pipeline hold request`
- `busy_o  out  1  state != IDLE`

## Operation
- States: IDLE, CALC, DONE. 6-bit iteration counter; 64-bit working register; latched op, sign flags and special-case result.
- IDLE, start_i=1, annul_i=0:
  - Latch op and operand magnitudes.
  - Signed ops (MUL/MULH/DIV/REM) take two's-complement absolute values of both operands. MULHSU takes the absolute value of reg1_i only.
  - Special case present: go to DONE.
  - Otherwise: go to CALC with counter=0.
- Special cases (DONE next cycle):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give reg1_i.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
- CALC:
  - Division: one restoring shift-subtract step per cycle.
  - Multiply: one shift-add step per cycle on the 64-bit product.
  - Counter 31 → DONE.
- DONE:
  - ready_o=1; result_o applies the sign fix-up:
    - Quotient is negated when operand signs differ.
    - Remainder takes the dividend's sign.
    - Product is negated when operand signs differ (signed operands only).
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - Always → IDLE. start_i still high in DONE is the same instruction and must not restart.
- annul_i=1 in any state: → IDLE at the next edge. ready_o=0 and stallreq_o=0 combinationally in that cycle. Partial result discarded.
- stallreq_o = (IDLE & start_i & !annul_i) | CALC. It is low in DONE so the pipeline advances.
- Width rules: all arithmetic is unsigned on magnitudes; negation is ~x+1 on 32 or 64 bits. The counter wraps only through the reset to 0 on IDLE→CALC.

## Timing
- Reset (asynchronous, rst=0): state=IDLE, counter=0, result_o=0, ready_o=0, stallreq_o=0, busy_o=0.
- Iterative op accepted at cycle 0:
  - CALC occupies cycles 1–32.
  - ready_o is high in cycle 33 only.
  - stallreq_o is high in cycles 0–32 (33 stall cycles).
- Fast path: stallreq_o high in cycle 0 only; ready_o high in cycle 1.
- Back-to-back: the next start_i is accepted in the cycle after DONE.
- Reset mid-operation: immediate IDLE, with no ready_o pulse.
- All outputs except stallreq_o are registered or decoded from state.

## Configuration
- `MDU_MUL_EN` defined: multiply ops run the 32-cycle shift-add path described above.
- `MDU_MUL_EN` undefined:
  - Multiply logic is removed.
  - Ops 000–011 take the fast path and return result_o=0 with ready_o in cycle 1.
  - Divide behaviour is unchanged.

## Test plan
- DIVU 100/7: ready_o in cycle 33 with result_o=14; REMU of the same operands gives 2; stallreq_o high for exactly 33 cycles.
- REM 0xFFFFFFF9 (−7) by 2: result_o=0xFFFFFFFF (−1). DIV of the same operands: 0xFFFFFFFD (−3).
- DIV 5/0: ready_o in cycle 1 with 0xFFFFFFFF. REM 5/0 gives 5. DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
- MULH 0xFFFFFFFF×0xFFFFFFFF gives 0. MULHU of the same operands gives 0xFFFFFFFE. MUL 0x10000×0x10000 gives 0. With MDU_MUL_EN undefined, each of these gives 0 in cycle 1.
- annul_i at cycle 10 of a DIVU: IDLE at cycle 11, no ready_o pulse; a new start_i at cycle 11 is accepted and completes in cycle 44.
- rst low at cycle 5 of a DIV: all outputs 0 immediately; after release, IDLE and a new op completes normally.

Source files
------------

// File: rtl/mdu_if.sv
// mdu_if: EX <-> multiply/divide sequencer handshake bundle.
//   start_i    : EX holds an M-op (op/operands stable while stallreq_o=1)
//   op_i       : RV32M funct3
//   reg1_i     : rs1 value (multiplicand / dividend)
//   reg2_i     : rs2 value (multiplier / divisor)
//   annul_i    : flush, abort current op
//   result_o   : result, valid while ready_o=1
//   ready_o    : one-cycle result-valid pulse
//   stallreq_o : pipeline hold request
//   busy_o     : sequencer not idle
// master = EX side, slave = mdu_ctrl.
interface mdu_if;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        annul_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;
    logic        busy_o;

    modport master (
        output start_i, op_i, reg1_i, reg2_i, annul_i,
        input  result_o, ready_o, stallreq_o, busy_o
    );

    modport slave (
        input  start_i, op_i, reg1_i, reg2_i, annul_i,
        output result_o, ready_o, stallreq_o, busy_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative RV32M multiply/divide sequencer for the execute stage.
// Runs one op over 32 CALC cycles (restoring divide / shift-add multiply) or
// through a single-cycle fast path for RISC-V special cases, stalling EX
// until the result is presented for one cycle.
// Ports:
//   clk : core clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : mdu_if.slave (start/op/operands/annul in; result/ready/stall/busy out)
// Build option: define MDU_MUL_EN to include the multiplier; when undefined,
// multiply ops take the fast path and return 0.
module mdu_ctrl (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   wr_q, wr_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic            rem_q, rem_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [W-1:0]    result_q, result_d;
`ifdef MDU_MUL_EN
    logic            mul_q, mul_d;
    logic            mul_lo_q, mul_lo_d;
    logic [W:0]      sum_c;
    logic [DW-1:0]   prod_c;
`endif

    logic            accept_c;
    logic            sgn_ops_c, hsu_c;
    logic [W-1:0]    abs1_c, abs2_c;
    logic            neg_res_c, neg_rem_c;
    logic            special_c;
    logic [W-1:0]    spec_res_c;
    logic [W:0]      diff_c;
    logic [DW-1:0]   step_c;
    logic [W-1:0]    quot_c, remv_c, fin_c;

    assign accept_c = (state_q == IDLE) && bus.start_i && !bus.annul_i;

    // Operand decode: magnitudes, sign fix-up flags, special-case detection
    always_comb begin
        sgn_ops_c  = (bus.op_i == 3'b000) || (bus.op_i == 3'b001) ||
                     (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
        hsu_c      = (bus.op_i == 3'b010);
        abs1_c     = ((sgn_ops_c || hsu_c) && bus.reg1_i[W-1]) ? W'(~bus.reg1_i + 32'd1) : bus.reg1_i;
        abs2_c     = (sgn_ops_c && bus.reg2_i[W-1]) ? W'(~bus.reg2_i + 32'd1) : bus.reg2_i;
        // MULHSU: only rs1 is signed, so its sign alone decides the product sign
        neg_res_c  = sgn_ops_c ? (bus.reg1_i[W-1] ^ bus.reg2_i[W-1]) : (hsu_c && bus.reg1_i[W-1]);
        neg_rem_c  = sgn_ops_c && bus.reg1_i[W-1];
        special_c  = 1'b0;
        spec_res_c = '0;
        if (bus.op_i[2]) begin
            if (bus.reg2_i == '0) begin
                special_c  = 1'b1;
                spec_res_c = bus.op_i[1] ? bus.reg1_i : '1;
            end else if (!bus.op_i[0] && (bus.reg1_i == 32'h8000_0000) && (bus.reg2_i == '1)) begin
                special_c  = 1'b1;
                spec_res_c = bus.op_i[1] ? '0 : 32'h8000_0000;
            end
        end
`ifndef MDU_MUL_EN
        if (!bus.op_i[2]) special_c = 1'b1;
`endif
    end

    // One iteration step on the working register
    always_comb begin
        // 33-bit trial subtract on the shifted partial remainder
        diff_c = wr_q[DW-1:W-1] - {1'b0, opnd_q};
        step_c = diff_c[W] ? {wr_q[DW-2:0], 1'b0} : {diff_c[W-1:0], wr_q[W-2:0], 1'b1};
`ifdef MDU_MUL_EN
        sum_c = {1'b0, wr_q[DW-1:W]} + {1'b0, opnd_q};
        if (mul_q) step_c = wr_q[0] ? {sum_c, wr_q[W-1:1]} : {1'b0, wr_q[DW-1:1]};
`endif
    end

    // Sign fix-up applied to the final step's value
    always_comb begin
        quot_c = neg_res_q ? W'(~step_c[W-1:0] + 32'd1) : step_c[W-1:0];
        remv_c = neg_rem_q ? W'(~step_c[DW-1:W] + 32'd1) : step_c[DW-1:W];
        fin_c  = rem_q ? remv_c : quot_c;
`ifdef MDU_MUL_EN
        prod_c = neg_res_q ? DW'(~step_c + 64'd1) : step_c;
        if (mul_q) fin_c = mul_lo_q ? prod_c[W-1:0] : prod_c[DW-1:W];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = special_c ? DONE : CALC;
            CALC:    if (cnt_q == CW'(31)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.annul_i) state_d = IDLE;
    end

    // Datapath next values
    always_comb begin
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        opnd_d    = opnd_q;
        rem_d     = rem_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
`ifdef MDU_MUL_EN
        mul_d     = mul_q;
        mul_lo_d  = mul_lo_q;
`endif
        case (state_q)
            IDLE: if (accept_c) begin
                cnt_d     = '0;
                rem_d     = bus.op_i[1];
                neg_res_d = neg_res_c;
                neg_rem_d = neg_rem_c;
                wr_d      = {32'd0, abs1_c};
                opnd_d    = abs2_c;
`ifdef MDU_MUL_EN
                mul_d     = !bus.op_i[2];
                mul_lo_d  = (bus.op_i == 3'b000);
                // Multiplier shifts through the low half; multiplicand is added
                if (!bus.op_i[2]) begin
                    wr_d   = {32'd0, abs2_c};
                    opnd_d = abs1_c;
                end
`endif
                if (special_c) result_d = spec_res_c;
            end
            CALC: begin
                wr_d  = step_c;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CW'(31)) result_d = fin_c;
            end
            DONE:    result_d = '0;
            default: result_d = '0;
        endcase
        if (bus.annul_i) result_d = '0;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            wr_q      <= '0;
            opnd_q    <= '0;
            rem_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
`ifdef MDU_MUL_EN
            mul_q     <= 1'b0;
            mul_lo_q  <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            opnd_q    <= opnd_d;
            rem_q     <= rem_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
`ifdef MDU_MUL_EN
            mul_q     <= mul_d;
            mul_lo_q  <= mul_lo_d;
`endif
        end
    end

    // Outputs decoded from state; flush and reset force the handshake low
    always_comb begin
        bus.stallreq_o = 1'b0;
        bus.ready_o    = 1'b0;
        bus.busy_o     = (state_q != IDLE);
        bus.result_o   = result_q;
        case (state_q)
            IDLE:    bus.stallreq_o = bus.start_i;
            CALC:    bus.stallreq_o = 1'b1;
            DONE:    bus.ready_o    = 1'b1;
            default: bus.stallreq_o = 1'b0;
        endcase
        if (bus.annul_i || !rst) begin
            bus.stallreq_o = 1'b0;
            bus.ready_o    = 1'b0;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed, table-driven bench for mdu_ctrl plus hand-written
// flush and mid-operation reset sequences. Multiply expectations follow
// MDU_MUL_EN.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mdu_if bus ();
    mdu_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.reg1_i  = a;
        bus.reg2_i  = b;
    endtask

    // Called #1 after the edge that opens cycle 0; returns #1 after the edge
    // that ends the DONE cycle, so the caller may start the next op at once.
    task automatic await_ready(input string name, input logic [31:0] exp_res, input int exp_cyc);
        int          got;
        int          stalls;
        logic [31:0] res;
        got    = -1;
        stalls = 0;
        res    = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check($sformatf("%s_idle_busy", name), 32'(bus.busy_o), 32'd0);
                check($sformatf("%s_idle_ready", name), 32'(bus.ready_o), 32'd0);
            end
            if (bus.stallreq_o) stalls++;
            if (bus.ready_o) begin
                got = c;
                res = bus.result_o;
            end
            @(posedge clk);
            #1;
            if (got >= 0) break;
        end
        check($sformatf("%s_result", name), res, exp_res);
        check($sformatf("%s_ready_cycle", name), 32'(got), 32'(exp_cyc));
        check($sformatf("%s_stall_cycles", name), 32'(stalls), 32'(exp_cyc));
    endtask

    initial begin
        int seen;

        // Division: unsigned, signed, overflow and divide-by-zero
        vecs.push_back('{3'b101, 32'd100,        32'd7,          32'd14,         33});
        vecs.push_back('{3'b111, 32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
        vecs.push_back('{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{3'b110, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{3'b111, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
        vecs.push_back('{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
        vecs.push_back('{3'b100, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33});
        vecs.push_back('{3'b110, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33});
        vecs.push_back('{3'b100, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  33});
        vecs.push_back('{3'b110, 32'd100,        32'hFFFF_FFF9,  32'd2,          33});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
`ifdef MDU_MUL_EN
        vecs.push_back('{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          33});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33});
        vecs.push_back('{3'b000, 32'h0001_0000,  32'h0001_0000,  32'd0,          33});
        vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD,  32'hFFFF_FFEB,  33});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{3'b001, 32'h4000_0000,  32'd4,          32'd1,          33});
`else
        vecs.push_back('{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{3'b000, 32'h0001_0000,  32'h0001_0000,  32'd0,          1});
        vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD,  32'd0,          1});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'd2,          32'd0,          1});
        vecs.push_back('{3'b001, 32'h4000_0000,  32'd4,          32'd0,          1});
`endif

        bus.start_i = 1'b0;
        bus.op_i    = 3'b000;
        bus.reg1_i  = '0;
        bus.reg2_i  = '0;
        bus.annul_i = 1'b0;
        rst         = 1'b1;
        #2 rst = 1'b0;
        #2;
        check("reset_result", bus.result_o, 32'd0);
        check("reset_ready", 32'(bus.ready_o), 32'd0);
        check("reset_stall", 32'(bus.stallreq_o), 32'd0);
        check("reset_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table: each op starts in the cycle right after the previous DONE
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            await_ready($sformatf("v%0d", i), vecs[i].exp, vecs[i].cyc);
        end
        bus.start_i = 1'b0;

        // Flush while idle with start held: no stall, stays idle
        @(posedge clk);
        #1;
        drive(3'b100, 32'd5, 32'd0);
        bus.annul_i = 1'b1;
        @(negedge clk);
        check("idle_annul_stall", 32'(bus.stallreq_o), 32'd0);
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("idle_annul_busy", 32'(bus.busy_o), 32'd0);
        check("idle_annul_ready", 32'(bus.ready_o), 32'd0);

        // Flush at cycle 10 of a DIVU, new op accepted at cycle 11
        @(posedge clk);
        #1;
        drive(3'b101, 32'd100, 32'd7);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.ready_o) seen = 1;
            @(posedge clk);
            #1;
        end
        check("annul_early_ready", 32'(seen), 32'd0);
        bus.annul_i = 1'b1;
        @(negedge clk);
        check("annul_stall", 32'(bus.stallreq_o), 32'd0);
        check("annul_ready", 32'(bus.ready_o), 32'd0);
        check("annul_busy_calc", 32'(bus.busy_o), 32'd1);
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        drive(3'b101, 32'd1000, 32'd3);
        await_ready("annul_restart", 32'd333, 33);
        bus.start_i = 1'b0;

        // Reset at cycle 5 of a DIV, then a normal op
        @(posedge clk);
        #1;
        drive(3'b100, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_result", bus.result_o, 32'd0);
        check("midrst_ready", 32'(bus.ready_o), 32'd0);
        check("midrst_stall", 32'(bus.stallreq_o), 32'd0);
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("postrst_busy", 32'(bus.busy_o), 32'd0);
        check("postrst_ready", 32'(bus.ready_o), 32'd0);
        @(posedge clk);
        #1;
        drive(3'b101, 32'd100, 32'd7);
        await_ready("postrst_divu", 32'd14, 33);
        bus.start_i = 1'b0;

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
